// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: PC/SP micro-ops, branch, flags,
// source/destination read ports, autoincrement and write-back port.
interface param_register_file_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic [1:0]       MO;
  logic             BranchExecute;
  logic [WIDTH-1:0] BranchAddress;
  logic             SRW;
  logic [3:0]       flagsIn;
  logic [AW-1:0]    srcA;
  logic [AW-1:0]    dstA;
  logic [1:0]       As;
  logic             Ad;
  logic             incSrc;
  logic             incDst;
  logic             BW;
  logic [AW-1:0]    resultA;
  logic             RW;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] Rsrc;
  logic [WIDTH-1:0] Rdst;
  logic [WIDTH-1:0] PCout;
  logic [WIDTH-1:0] SPout;
  logic [3:0]       flagsOut;

  modport master (
    output MO, BranchExecute, BranchAddress, SRW, flagsIn,
    output srcA, dstA, As, Ad, incSrc, incDst, BW,
    output resultA, RW, dataIn,
    input  Rsrc, Rdst, PCout, SPout, flagsOut
  );

  modport slave (
    input  MO, BranchExecute, BranchAddress, SRW, flagsIn,
    input  srcA, dstA, As, Ad, incSrc, incDst, BW,
    input  resultA, RW, dataIn,
    output Rsrc, Rdst, PCout, SPout, flagsOut
  );
endinterface

// File: rtl/param_register_file.sv
// CPU register file: R0=PC, R1=SP, R2=SR/CG1, R3=CG2, R4.. general purpose.
// Optional macro PARAM_REGFILE_BYPASS_EN forwards same-cycle write data to Rsrc/Rdst.
module param_register_file #(
  parameter int               WIDTH   = 16,
  parameter int               NREGS   = 16,
  parameter logic [WIDTH-1:0] SR_MASK = 'h01FF
) (
  input logic                 clk,
  input logic                 reset,
  param_register_file_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  // V flag lives at bit 8; narrow builds fold it onto the top bit
  localparam int VB = (WIDTH > 8) ? 8 : WIDTH - 1;
  localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] r   [NREGS];
  logic [WIDTH-1:0] nxt [NREGS];
  logic [NREGS-1:0] inc_hit;
  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] pc_adv;
  logic [WIDTH-1:0] sp_adj;
  logic [WIDTH-1:0] src_rd;
  logic [WIDTH-1:0] dst_rd;

  function automatic logic [WIDTH-1:0] cg_val(input logic             is_r3,
                                              input logic [1:0]       mode,
                                              input logic [WIDTH-1:0] srv);
    logic [WIDTH-1:0] v;
    case ({is_r3, mode})
      3'b000:  v = srv;
      3'b001:  v = '0;
      3'b010:  v = WIDTH'(4);
      3'b011:  v = WIDTH'(8);
      3'b100:  v = '0;
      3'b101:  v = WIDTH'(1);
      3'b110:  v = WIDTH'(2);
      default: v = '1;
    endcase
    return v;
  endfunction

  // Write-back value after per-register forcing (even PC/SP, masked SR)
  always_comb begin
    wval = bus.dataIn;
    if (bus.resultA == AW'(0) || bus.resultA == AW'(1)) begin
      wval[0] = 1'b0;
    end else if (bus.resultA == AW'(2)) begin
      wval = bus.dataIn & SR_MASK;
    end
  end

  // A register incremented by both incSrc and incDst still gets one step
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      inc_hit[i] = (i != 2) && (i != 3) &&
                   ((bus.incSrc && bus.srcA == AW'(i)) ||
                    (bus.incDst && bus.dstA == AW'(i)));
    end
  end

  always_comb begin
    pc_adv = ZERO;
    if (bus.MO == 2'b01 || bus.MO == 2'b10) pc_adv = pc_adv + TWO;
    if (inc_hit[0]) pc_adv = pc_adv + TWO;

    sp_adj = ZERO;
    if (bus.MO == 2'b11) sp_adj = sp_adj - TWO;
    if (inc_hit[1]) sp_adj = sp_adj + TWO;

    for (int unsigned i = 0; i < NREGS; i++) begin
      nxt[i] = r[i];
    end

    if (bus.BranchExecute) begin
      nxt[0] = bus.BranchAddress;
    end else begin
      nxt[0] = r[0] + pc_adv;
    end
    nxt[0][0] = 1'b0;

    nxt[1]    = r[1] + sp_adj;
    nxt[1][0] = 1'b0;

    if (bus.SRW) begin
      nxt[2][1]  = bus.flagsIn[3];
      nxt[2][2]  = bus.flagsIn[2];
      nxt[2][VB] = bus.flagsIn[1];
      nxt[2][0]  = bus.flagsIn[0];
      nxt[2]     = nxt[2] & SR_MASK;
    end

    for (int unsigned i = 4; i < NREGS; i++) begin
      if (inc_hit[i]) nxt[i] = r[i] + (bus.BW ? WIDTH'(1) : TWO);
    end

    // Write-back is applied last so it wins over every other update
    if (bus.RW && bus.resultA != AW'(3)) begin
      nxt[bus.resultA] = wval;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r[i] <= nxt[i];
      end
    end
  end

  always_comb begin
    src_rd = r[bus.srcA];
    dst_rd = r[bus.dstA];
`ifdef PARAM_REGFILE_BYPASS_EN
    if (bus.RW && bus.resultA == bus.srcA) src_rd = wval;
    if (bus.RW && bus.resultA == bus.dstA) dst_rd = wval;
`endif
  end

  // Constant-generator decode; R2 in mode 00 is the plain SR read
  always_comb begin
    if (bus.srcA == AW'(2) || bus.srcA == AW'(3)) begin
      bus.Rsrc = cg_val(bus.srcA[0], bus.As, src_rd);
    end else begin
      bus.Rsrc = src_rd;
    end
    if (bus.dstA == AW'(2) || bus.dstA == AW'(3)) begin
      bus.Rdst = cg_val(bus.dstA[0], {1'b0, bus.Ad}, dst_rd);
    end else begin
      bus.Rdst = dst_rd;
    end
  end

  assign bus.PCout    = r[0];
  assign bus.SPout    = r[1];
  assign bus.flagsOut = {r[2][1], r[2][2], r[2][VB], r[2][0]};

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file (16-bit, 16 registers).
module tb_param_register_file;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  param_register_file_if #(.WIDTH(16), .NREGS(16)) bus ();

  param_register_file #(
    .WIDTH  (16),
    .NREGS  (16),
    .SR_MASK(16'h01FF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    bus.MO = 2'b00; bus.BranchExecute = 1'b0; bus.BranchAddress = '0;
    bus.SRW = 1'b0; bus.flagsIn = '0; bus.srcA = '0; bus.dstA = '0;
    bus.As = 2'b00; bus.Ad = 1'b0; bus.incSrc = 1'b0; bus.incDst = 1'b0;
    bus.BW = 1'b0; bus.resultA = '0; bus.RW = 1'b0; bus.dataIn = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.RW = 1'b1; bus.resultA = a; bus.dataIn = d;
    cyc();
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] v);
    bus.srcA = a; bus.As = 2'b00;
    #1;
    v = bus.Rsrc;
  endtask

  task automatic test_reset();
    logic [15:0] exp_cg [4];
    logic [15:0] v;
    clr();
    reset = 1'b0;
    #3;
    total++; if (bus.PCout !== 16'h0000) begin $display("FAIL reset_pc got=%h required=0000", bus.PCout); bad++; end
    total++; if (bus.SPout !== 16'h0000) begin $display("FAIL reset_sp got=%h required=0000", bus.SPout); bad++; end
    total++; if (bus.flagsOut !== 4'b0000) begin $display("FAIL reset_flags got=%b required=0000", bus.flagsOut); bad++; end
    rd(4'd4, v);
    total++; if (v !== 16'h0000) begin $display("FAIL reset_r4 got=%h required=0000", v); bad++; end
    exp_cg = '{16'h0000, 16'h0001, 16'h0002, 16'hFFFF};
    for (int m = 0; m < 4; m++) begin
      bus.srcA = 4'd3; bus.As = 2'(m);
      #1;
      total++; if (bus.Rsrc !== exp_cg[m]) begin $display("FAIL reset_cg2_as%0d got=%h required=%h", m, bus.Rsrc, exp_cg[m]); bad++; end
    end
    repeat (2) @(posedge clk);
    #5 reset = 1'b1;
    clr();
  endtask

  task automatic test_flags();
    logic [15:0] v;
    bus.SRW = 1'b1; bus.flagsIn = 4'b1011;
    cyc();
    rd(4'd2, v);
    total++; if (bus.flagsOut !== 4'b1011) begin $display("FAIL flags_1011 got=%b required=1011", bus.flagsOut); bad++; end
    total++; if (v !== 16'h0103) begin $display("FAIL sr_1011 got=%h required=0103", v); bad++; end
    bus.SRW = 1'b1; bus.flagsIn = 4'b0101;
    cyc();
    rd(4'd2, v);
    total++; if (bus.flagsOut !== 4'b0101) begin $display("FAIL flags_0101 got=%b required=0101", bus.flagsOut); bad++; end
    total++; if (v !== 16'h0005) begin $display("FAIL sr_0101 got=%h required=0005", v); bad++; end
  endtask

  task automatic test_branch();
    bus.BranchExecute = 1'b1; bus.BranchAddress = 16'd21;
    cyc();
    total++; if (bus.PCout !== 16'd20) begin $display("FAIL branch_odd got=%0d required=20", bus.PCout); bad++; end
    bus.BranchExecute = 1'b1; bus.BranchAddress = 16'd30;
    bus.RW = 1'b1; bus.resultA = 4'd0; bus.dataIn = 16'd40;
    cyc();
    total++; if (bus.PCout !== 16'd40) begin $display("FAIL branch_vs_rw got=%0d required=40", bus.PCout); bad++; end
    bus.BranchExecute = 1'b1; bus.BranchAddress = 16'h0100; bus.MO = 2'b01;
    cyc();
    total++; if (bus.PCout !== 16'h0100) begin $display("FAIL branch_vs_mo got=%h required=0100", bus.PCout); bad++; end
  endtask

  task automatic test_pc_sp();
    wr(4'd1, 16'h2400);
    bus.MO = 2'b11;
    cyc();
    total++; if (bus.SPout !== 16'h23FE) begin $display("FAIL sp_predec got=%h required=23FE", bus.SPout); bad++; end
    wr(4'd0, 16'h0000);
    bus.MO = 2'b01; cyc();
    bus.MO = 2'b01; cyc();
    total++; if (bus.PCout !== 16'h0004) begin $display("FAIL pc_next2 got=%h required=0004", bus.PCout); bad++; end
    bus.MO = 2'b10; cyc();
    total++; if (bus.PCout !== 16'h0006) begin $display("FAIL pc_offset got=%h required=0006", bus.PCout); bad++; end
    bus.MO = 2'b00; cyc();
    total++; if (bus.PCout !== 16'h0006) begin $display("FAIL pc_nop got=%h required=0006", bus.PCout); bad++; end
    wr(4'd1, 16'h0000);
    bus.MO = 2'b11; cyc();
    total++; if (bus.SPout !== 16'hFFFE) begin $display("FAIL sp_wrap got=%h required=FFFE", bus.SPout); bad++; end
    wr(4'd0, 16'hFFFE);
    bus.MO = 2'b01; cyc();
    total++; if (bus.PCout !== 16'h0000) begin $display("FAIL pc_wrap got=%h required=0000", bus.PCout); bad++; end
    wr(4'd0, 16'h0033);
    total++; if (bus.PCout !== 16'h0032) begin $display("FAIL pc_even got=%h required=0032", bus.PCout); bad++; end
    bus.MO = 2'b01; bus.RW = 1'b1; bus.resultA = 4'd0; bus.dataIn = 16'h0010;
    cyc();
    total++; if (bus.PCout !== 16'h0010) begin $display("FAIL rw_vs_mo got=%h required=0010", bus.PCout); bad++; end
  endtask

  task automatic test_sr_cg();
    logic [15:0] v;
    logic [15:0] exp_r2 [4];
    wr(4'd2, 16'h4321);
    rd(4'd2, v);
    total++; if (v !== 16'h0121) begin $display("FAIL sr_mask got=%h required=0121", v); bad++; end
    wr(4'd3, 16'd24);
    rd(4'd3, v);
    total++; if (v !== 16'h0000) begin $display("FAIL r3_write got=%h required=0000", v); bad++; end
    exp_r2 = '{16'h0121, 16'h0000, 16'h0004, 16'h0008};
    for (int m = 0; m < 4; m++) begin
      bus.srcA = 4'd2; bus.As = 2'(m);
      #1;
      total++; if (bus.Rsrc !== exp_r2[m]) begin $display("FAIL cg1_as%0d got=%h required=%h", m, bus.Rsrc, exp_r2[m]); bad++; end
    end
    bus.dstA = 4'd2; bus.Ad = 1'b0; #1;
    total++; if (bus.Rdst !== 16'h0121) begin $display("FAIL rdst_r2_ad0 got=%h required=0121", bus.Rdst); bad++; end
    bus.Ad = 1'b1; #1;
    total++; if (bus.Rdst !== 16'h0000) begin $display("FAIL rdst_r2_ad1 got=%h required=0000", bus.Rdst); bad++; end
    bus.dstA = 4'd3; bus.Ad = 1'b0; #1;
    total++; if (bus.Rdst !== 16'h0000) begin $display("FAIL rdst_r3_ad0 got=%h required=0000", bus.Rdst); bad++; end
    bus.Ad = 1'b1; #1;
    total++; if (bus.Rdst !== 16'h0001) begin $display("FAIL rdst_r3_ad1 got=%h required=0001", bus.Rdst); bad++; end
    clr();
    bus.SRW = 1'b1; bus.flagsIn = 4'b0000;
    cyc();
    rd(4'd2, v);
    total++; if (v !== 16'h0020) begin $display("FAIL srw_hold got=%h required=0020", v); bad++; end
    bus.SRW = 1'b1; bus.flagsIn = 4'b1111;
    bus.RW = 1'b1; bus.resultA = 4'd2; bus.dataIn = 16'h00F0;
    cyc();
    rd(4'd2, v);
    total++; if (v !== 16'h00F0) begin $display("FAIL rw_vs_srw got=%h required=00F0", v); bad++; end
  endtask

  task automatic test_autoinc();
    logic [15:0] v;
    wr(4'd6, 16'h0060);
    bus.incDst = 1'b1; bus.dstA = 4'd6; bus.BW = 1'b1; cyc();
    rd(4'd6, v);
    total++; if (v !== 16'h0061) begin $display("FAIL inc_byte got=%h required=0061", v); bad++; end
    bus.incDst = 1'b1; bus.dstA = 4'd6; bus.BW = 1'b0; cyc();
    bus.dstA = 4'd6; bus.Ad = 1'b1; #1;
    total++; if (bus.Rdst !== 16'h0063) begin $display("FAIL inc_word got=%h required=0063", bus.Rdst); bad++; end
    clr();
    wr(4'd1, 16'h2400);
    bus.incDst = 1'b1; bus.dstA = 4'd1; bus.BW = 1'b1; cyc();
    total++; if (bus.SPout !== 16'h2402) begin $display("FAIL inc_sp_bw got=%h required=2402", bus.SPout); bad++; end
    wr(4'd5, 16'h0050);
    bus.incSrc = 1'b1; bus.srcA = 4'd5; bus.incDst = 1'b1; bus.dstA = 4'd5; cyc();
    rd(4'd5, v);
    total++; if (v !== 16'h0052) begin $display("FAIL inc_same_reg got=%h required=0052", v); bad++; end
    wr(4'd2, 16'h0011);
    bus.incSrc = 1'b1; bus.srcA = 4'd2; cyc();
    rd(4'd2, v);
    total++; if (v !== 16'h0011) begin $display("FAIL inc_cg1 got=%h required=0011", v); bad++; end
    wr(4'd0, 16'h0100);
    bus.incSrc = 1'b1; bus.srcA = 4'd0; bus.MO = 2'b01; cyc();
    total++; if (bus.PCout !== 16'h0104) begin $display("FAIL inc_pc_mo got=%h required=0104", bus.PCout); bad++; end
    wr(4'd4, 16'h0040);
    bus.incSrc = 1'b1; bus.srcA = 4'd4; bus.incDst = 1'b1; bus.dstA = 4'd5; bus.BW = 1'b1; cyc();
    rd(4'd4, v);
    total++; if (v !== 16'h0041) begin $display("FAIL inc_pair_src got=%h required=0041", v); bad++; end
    rd(4'd5, v);
    total++; if (v !== 16'h0053) begin $display("FAIL inc_pair_dst got=%h required=0053", v); bad++; end
    bus.incDst = 1'b1; bus.dstA = 4'd6; bus.RW = 1'b1; bus.resultA = 4'd6; bus.dataIn = 16'hABCD; cyc();
    rd(4'd6, v);
    total++; if (v !== 16'hABCD) begin $display("FAIL rw_vs_inc got=%h required=ABCD", v); bad++; end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    for (int i = 9; i < 13; i++) wr(4'(i), 16'(16'h0900 + i * 16));
    for (int i = 9; i < 13; i++) begin
      rd(4'(i), v);
      total++; if (v !== 16'(16'h0900 + i * 16)) begin $display("FAIL b2b_r%0d got=%h required=%h", i, v, 16'(16'h0900 + i * 16)); bad++; end
    end
  endtask

  task automatic test_bypass();
    logic [15:0] v;
    logic [15:0] exp_src;
    wr(4'd7, 16'h0011);
    @(negedge clk);
    bus.RW = 1'b1; bus.resultA = 4'd7; bus.dataIn = 16'h0070;
    bus.srcA = 4'd7; bus.dstA = 4'd7; bus.As = 2'b00;
    #1;
`ifdef PARAM_REGFILE_BYPASS_EN
    exp_src = 16'h0070;
`else
    exp_src = 16'h0011;
`endif
    total++; if (bus.Rsrc !== exp_src) begin $display("FAIL bypass_src got=%h required=%h", bus.Rsrc, exp_src); bad++; end
    total++; if (bus.Rdst !== exp_src) begin $display("FAIL bypass_dst got=%h required=%h", bus.Rdst, exp_src); bad++; end
    cyc();
    rd(4'd7, v);
    total++; if (v !== 16'h0070) begin $display("FAIL bypass_commit got=%h required=0070", v); bad++; end
    @(negedge clk);
    bus.RW = 1'b1; bus.resultA = 4'd2; bus.dataIn = 16'hFFFF; bus.srcA = 4'd2; bus.As = 2'b10;
    #1;
    total++; if (bus.Rsrc !== 16'h0004) begin $display("FAIL bypass_cg got=%h required=0004", bus.Rsrc); bad++; end
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    wr(4'd8, 16'h8888);
    wr(4'd0, 16'h0200);
    bus.SRW = 1'b1; bus.flagsIn = 4'b1111; cyc();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (bus.PCout !== 16'h0000) begin $display("FAIL async_pc got=%h required=0000", bus.PCout); bad++; end
    total++; if (bus.flagsOut !== 4'b0000) begin $display("FAIL async_flags got=%b required=0000", bus.flagsOut); bad++; end
    rd(4'd8, v);
    total++; if (v !== 16'h0000) begin $display("FAIL async_r8 got=%h required=0000", v); bad++; end
    bus.RW = 1'b1; bus.resultA = 4'd8; bus.dataIn = 16'h0055; bus.MO = 2'b01;
    cyc();
    rd(4'd8, v);
    total++; if (v !== 16'h0000) begin $display("FAIL reset_edge_r8 got=%h required=0000", v); bad++; end
    total++; if (bus.PCout !== 16'h0000) begin $display("FAIL reset_edge_pc got=%h required=0000", bus.PCout); bad++; end
    #2 reset = 1'b1;
    bus.RW = 1'b1; bus.resultA = 4'd8; bus.dataIn = 16'h0055; bus.MO = 2'b01;
    cyc();
    rd(4'd8, v);
    total++; if (v !== 16'h0055) begin $display("FAIL first_edge_r8 got=%h required=0055", v); bad++; end
    total++; if (bus.PCout !== 16'h0002) begin $display("FAIL first_edge_pc got=%h required=0002", bus.PCout); bad++; end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_flags();
    test_branch();
    test_pc_sp();
    test_sr_cg();
    test_autoinc();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
